// File: rtl/ifetch_sram_bridge_if.sv
// SRAM-like instruction port between the fetch bridge (master) and the
// instruction memory or cache (slave).
interface ifetch_sram_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              inst_req;
    logic              inst_wr;
    logic [1:0]        inst_size;
    logic [ADDR_W-1:0] inst_addr;
    logic [ADDR_W-1:0] inst_wdata;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [ADDR_W-1:0] inst_rdata;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/ifetch_sram_bridge.sv
// Fetch-side bridge: one SRAM-like read per F-stage PC, holds the word under
// stall, drops stale responses after a flush and flags misaligned PCs.
module ifetch_sram_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] instr_,
    output logic              i_data_ok,
    output logic              fetch_adel,
    ifetch_sram_bridge_if.master inst
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DISCARD} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] hold_q;
    logic              capture;
    logic              aligned;

    assign aligned         = (pc[1:0] == 2'b00);
    assign inst.inst_req   = (state == REQ) && aligned && !flush && resetn;
    assign inst.inst_wr    = 1'b0;
    assign inst.inst_size  = 2'b10;
    assign inst.inst_addr  = pc;
    assign inst.inst_wdata = '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= REQ;
            hold_q <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                hold_q <= inst.inst_rdata;
            end
        end
    end

    // Outputs are also forced low while resetn is asserted, since the state
    // register alone would still let a misaligned pc raise i_data_ok.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        i_data_ok  = 1'b0;
        fetch_adel = 1'b0;
        instr_     = '0;
        case (state)
            REQ: begin
                if (!aligned) begin
                    fetch_adel = 1'b1;
                    i_data_ok  = 1'b1;
                end else if (inst.inst_req && inst.inst_addr_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (inst.inst_data_ok) begin
                    state_next = REQ;
                    if (!flush) begin
                        i_data_ok = 1'b1;
                        instr_    = inst.inst_rdata;
                        capture   = 1'b1;
                        if (stall) begin
                            state_next = HOLD;
                        end
                    end
                end else if (flush) begin
                    state_next = DISCARD;
                end
            end
            HOLD: begin
                i_data_ok = 1'b1;
                instr_    = hold_q;
                if (!stall || flush) begin
                    state_next = REQ;
                end
            end
            DISCARD: begin
                if (inst.inst_data_ok) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
        if (!resetn) begin
            i_data_ok  = 1'b0;
            fetch_adel = 1'b0;
            instr_     = '0;
        end
    end
endmodule

// File: tb/tb_ifetch_sram_bridge.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stage and the SRAM-like slave.
module tb_ifetch_sram_bridge;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] pc = 32'hbfc00000;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_;
    logic        i_data_ok;
    logic        fetch_adel;
    int          checks = 0;
    int          errors = 0;

    ifetch_sram_bridge_if #(.ADDR_W(32)) bus ();

    ifetch_sram_bridge #(.ADDR_W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pc         (pc),
        .stall      (stall),
        .flush      (flush),
        .instr_     (instr_),
        .i_data_ok  (i_data_ok),
        .fetch_adel (fetch_adel),
        .inst       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'h5a5a0000;
    endfunction

    // Inputs change on the falling edge; outputs are then read before the rising edge.
    task automatic drive(input logic [31:0] p, input logic s, input logic f,
                         input logic aok, input logic dok, input logic [31:0] rd);
        @(negedge clk);
        pc                = p;
        stall             = s;
        flush             = f;
        bus.inst_addr_ok  = aok;
        bus.inst_data_ok  = dok;
        bus.inst_rdata    = rd;
        #1;
    endtask

    task automatic test_reset();
        bus.inst_addr_ok = 1'b1;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        resetn = 1'b0;
        drive(32'hbfc00000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", bus.inst_req); end
        checks++; if (i_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_ok: got %b expected 0", i_data_ok); end
        checks++; if (instr_ !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", instr_); end
        checks++; if (bus.inst_wr !== 1'b0 || bus.inst_size !== 2'b10 || bus.inst_wdata !== 32'h0) begin
            errors++; $display("[TB] FAIL const_outputs: got wr=%b size=%b wdata=%h expected 0/10/0", bus.inst_wr, bus.inst_size, bus.inst_wdata);
        end
        drive(32'hbfc00002, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (fetch_adel !== 1'b0 || i_data_ok !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_adel: got adel=%b ok=%b expected 0/0", fetch_adel, i_data_ok);
        end
        drive(32'hbfc00000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        resetn = 1'b1;
        #1;
        checks++; if (bus.inst_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_req: got %b expected 1", bus.inst_req); end
    endtask

    task automatic test_back_to_back();
        drive(32'hbfc00000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00000) begin
            errors++; $display("[TB] FAIL b2b_req0: got req=%b addr=%h expected 1/bfc00000", bus.inst_req, bus.inst_addr);
        end
        drive(32'hbfc00000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h24080001);
        checks++; if (i_data_ok !== 1'b1 || instr_ !== 32'h24080001) begin
            errors++; $display("[TB] FAIL b2b_data: got ok=%b instr=%h expected 1/24080001", i_data_ok, instr_);
        end
        checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_noreq_wait: got %b expected 0", bus.inst_req); end
        drive(32'hbfc00004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00004) begin
            errors++; $display("[TB] FAIL b2b_req1: got req=%b addr=%h expected 1/bfc00004", bus.inst_req, bus.inst_addr);
        end
        drive(32'hbfc00004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3c1d0001);
        checks++; if (i_data_ok !== 1'b1 || instr_ !== 32'h3c1d0001) begin
            errors++; $display("[TB] FAIL b2b_data1: got ok=%b instr=%h expected 1/3c1d0001", i_data_ok, instr_);
        end
    endtask

    task automatic test_hold_stall();
        drive(32'hbfc00008, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (bus.inst_req !== 1'b1) begin errors++; $display("[TB] FAIL hold_req: got %b expected 1", bus.inst_req); end
        drive(32'hbfc00008, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8c090004);
        checks++; if (i_data_ok !== 1'b1 || instr_ !== 32'h8c090004) begin
            errors++; $display("[TB] FAIL hold_first: got ok=%b instr=%h expected 1/8c090004", i_data_ok, instr_);
        end
        for (int i = 0; i < 3; i++) begin
            drive(32'hbfc00008, 1'b1, 1'b0, 1'b1, 1'b0, $urandom);
            checks++; if (i_data_ok !== 1'b1 || instr_ !== 32'h8c090004 || bus.inst_req !== 1'b0) begin
                errors++; $display("[TB] FAIL hold_cycle%0d: got ok=%b instr=%h req=%b expected 1/8c090004/0", i, i_data_ok, instr_, bus.inst_req);
            end
        end
        drive(32'hbfc00008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (i_data_ok !== 1'b1 || instr_ !== 32'h8c090004 || bus.inst_req !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_release: got ok=%b instr=%h req=%b expected 1/8c090004/0", i_data_ok, instr_, bus.inst_req);
        end
        drive(32'hbfc0000c, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.inst_req !== 1'b1 || i_data_ok !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_next_req: got req=%b ok=%b expected 1/0", bus.inst_req, i_data_ok);
        end
    endtask

    task automatic test_slow_slave();
        int accepts = 0;
        for (int i = 0; i < 6; i++) begin
            drive(32'hbfc00010, 1'b0, 1'b0, (i >= 4), 1'b0, 32'h0);
            if (i < 5) begin
                checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00010) begin
                    errors++; $display("[TB] FAIL slow_req%0d: got req=%b addr=%h expected 1/bfc00010", i, bus.inst_req, bus.inst_addr);
                end
            end
            if (bus.inst_req === 1'b1 && bus.inst_addr_ok === 1'b1) accepts++;
        end
        checks++; if (accepts !== 1) begin errors++; $display("[TB] FAIL slow_accepts: got %0d expected 1", accepts); end
        drive(32'hbfc00010, 1'b0, 1'b0, 1'b0, 1'b1, 32'hcafe0001);
        checks++; if (i_data_ok !== 1'b1 || instr_ !== 32'hcafe0001) begin
            errors++; $display("[TB] FAIL slow_data: got ok=%b instr=%h expected 1/cafe0001", i_data_ok, instr_);
        end
    endtask

    task automatic test_flush_wait();
        drive(32'hbfc00014, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (bus.inst_req !== 1'b1) begin errors++; $display("[TB] FAIL flush_req: got %b expected 1", bus.inst_req); end
        drive(32'hbfc00380, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (i_data_ok !== 1'b0 || bus.inst_req !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_cycle: got ok=%b req=%b expected 0/0", i_data_ok, bus.inst_req);
        end
        drive(32'hbfc00380, 1'b0, 1'b0, 1'b1, 1'b1, 32'hdeadbeef);
        checks++; if (i_data_ok !== 1'b0 || instr_ === 32'hdeadbeef || bus.inst_req !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_stale: got ok=%b instr=%h req=%b expected 0/not deadbeef/0", i_data_ok, instr_, bus.inst_req);
        end
        drive(32'hbfc00380, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00380) begin
            errors++; $display("[TB] FAIL flush_redirect: got req=%b addr=%h expected 1/bfc00380", bus.inst_req, bus.inst_addr);
        end
        drive(32'hbfc00380, 1'b0, 1'b0, 1'b0, 1'b1, 32'h42000018);
        checks++; if (i_data_ok !== 1'b1 || instr_ !== 32'h42000018) begin
            errors++; $display("[TB] FAIL flush_newdata: got ok=%b instr=%h expected 1/42000018", i_data_ok, instr_);
        end
    endtask

    task automatic test_misaligned();
        drive(32'hbfc00002, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11111111);
        checks++; if (bus.inst_req !== 1'b0 || fetch_adel !== 1'b1 || i_data_ok !== 1'b1 || instr_ !== 32'h0) begin
            errors++; $display("[TB] FAIL misaligned: got req=%b adel=%b ok=%b instr=%h expected 0/1/1/0", bus.inst_req, fetch_adel, i_data_ok, instr_);
        end
        drive(32'hbfc00004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.inst_req !== 1'b1 || fetch_adel !== 1'b0 || i_data_ok !== 1'b0) begin
            errors++; $display("[TB] FAIL misaligned_after: got req=%b adel=%b ok=%b expected 1/0/0", bus.inst_req, fetch_adel, i_data_ok);
        end
    endtask

    task automatic test_async_reset();
        drive(32'hbfc00040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        drive(32'hbfc00040, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11223344);
        checks++; if (i_data_ok !== 1'b1 || instr_ !== 32'h11223344) begin
            errors++; $display("[TB] FAIL areset_pre: got ok=%b instr=%h expected 1/11223344", i_data_ok, instr_);
        end
        #1 resetn = 1'b0;
        #1;
        checks++; if (bus.inst_req !== 1'b0 || i_data_ok !== 1'b0 || instr_ !== 32'h0) begin
            errors++; $display("[TB] FAIL areset_now: got req=%b ok=%b instr=%h expected 0/0/0", bus.inst_req, i_data_ok, instr_);
        end
        drive(32'hbfc00040, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(32'hbfc00040, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        resetn = 1'b1;
        #1;
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00040 || i_data_ok !== 1'b0) begin
            errors++; $display("[TB] FAIL areset_release: got req=%b addr=%h ok=%b expected 1/bfc00040/0", bus.inst_req, bus.inst_addr, i_data_ok);
        end
    endtask

    // Model: the slave holds at most one read, a flush marks it stale, a good
    // return under stall stays visible until the fetch stage moves on.
    task automatic test_random(input int cycles);
        logic        outstanding = 1'b0;
        logic        stale = 1'b0;
        logic        holding = 1'b0;
        logic [31:0] hold_val = 32'h0;
        logic [31:0] out_addr = 32'h0;
        logic [31:0] cur_pc = pc;
        logic [31:0] next_pc;
        int          countdown = 0;
        logic        f, s, dok, aok, exp_req, ret_good, exp_adel, exp_ok, aligned;
        logic [31:0] exp_instr;
        for (int c = 0; c < cycles; c++) begin
            f = ($urandom_range(11) == 0);
            s = ($urandom_range(2) == 0);
            if (f) begin
                cur_pc = 32'hbfc00000 + (32'($urandom_range(1023)) << 2);
                if ($urandom_range(5) == 0) cur_pc = cur_pc + 32'($urandom_range(3, 1));
            end
            dok = 1'b0;
            if (outstanding) begin
                if (countdown == 0) dok = 1'b1;
                else countdown--;
            end
            drive(cur_pc, s, f, 1'b0, dok, dok ? mem_word(out_addr) : $urandom);
            aligned = (cur_pc[1:0] == 2'b00);
            exp_req = !outstanding && !holding && aligned && !f;
            checks++; if (bus.inst_req !== exp_req || bus.inst_addr !== cur_pc) begin
                errors++; $display("[TB] FAIL rnd_req c=%0d: got req=%b addr=%h expected %b/%h", c, bus.inst_req, bus.inst_addr, exp_req, cur_pc);
            end
            aok = 1'($urandom_range(1));
            bus.inst_addr_ok = aok;
            #1;
            ret_good  = dok && !stale && !f;
            exp_adel  = !aligned && !outstanding && !holding;
            exp_ok    = ret_good || holding || exp_adel;
            exp_instr = ret_good ? mem_word(out_addr) : (holding ? hold_val : 32'h0);
            checks++; if (i_data_ok !== exp_ok || instr_ !== exp_instr || fetch_adel !== exp_adel) begin
                errors++; $display("[TB] FAIL rnd_out c=%0d: got ok=%b instr=%h adel=%b expected %b/%h/%b", c, i_data_ok, instr_, fetch_adel, exp_ok, exp_instr, exp_adel);
            end
            next_pc = cur_pc;
            if (exp_ok && !s && !f) next_pc = {cur_pc[31:2] + 30'd1, 2'b00};
            if (holding) holding = s && !f;
            else if (ret_good && s) begin
                holding  = 1'b1;
                hold_val = mem_word(out_addr);
            end
            if (dok) outstanding = 1'b0;
            if (outstanding && f) stale = 1'b1;
            if (exp_req && aok) begin
                outstanding = 1'b1;
                stale       = 1'b0;
                out_addr    = cur_pc;
                countdown   = $urandom_range(3);
            end
            cur_pc = next_pc;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold_stall();
        test_slow_slave();
        test_flush_wait();
        test_misaligned();
        test_async_reset();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_sram_bridge.md
Name: ifetch_sram_bridge

Overview:
- Fetch-side bus bridge between the F-stage PC register and an SRAM-like instruction port (req/addr_ok/data_ok).
- Issues one read per PC and returns the instruction word plus i_data_ok to the fetch stage and hazard unit.
- Holds a returned instruction while the pipeline is stalled.
- Discards in-flight responses when a flush redirects the PC.
- Flags misaligned PCs instead of issuing a bus request.

Parameters:
ADDR_W, 32, instruction address / data width

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
pc  input  32  current F-stage PC from freg
stall  input  1  stallF from hazard unit; 1 = F stage will not advance this cycle
flush  input  1  PC redirect (exception/eret) this cycle; in-flight fetch is stale
instr_  output  32  fetched instruction to fetch stage
i_data_ok  output  1  instr_ valid for current pc
fetch_adel  output  1  pc[1:0]!=0; instr_ forced 0
inst_req  output  1  SRAM-like request
inst_wr  output  1  constant 0
inst_size  output  2  constant 2'b10 (word)
inst_addr  output  32  equals pc
inst_wdata  output  32  constant 0
inst_addr_ok  input  1  request accepted
inst_data_ok  input  1  read data returned
inst_rdata  input  32  read data

Behaviour:
- Decided: one clock clk; reset resetn is asynchronous and active-low.
- States: REQ, WAIT, HOLD, DISCARD. Reset state is REQ.
- Outputs in reset: inst_req=0, i_data_ok=0, fetch_adel=0, instr_=0, hold register=0.
- aligned = (pc[1:0]==2'b00).
- inst_req = (state==REQ) && aligned && !flush && resetn.

REQ:
- Misaligned pc: no request, fetch_adel=1, i_data_ok=1, instr_=0, remain in REQ.
- inst_req && inst_addr_ok: go to WAIT.
- flush && inst_addr_ok in the same cycle cannot occur, because req is masked.
- Otherwise remain in REQ.

WAIT:
- inst_data_ok: instr_=inst_rdata and i_data_ok=1 in the same cycle (zero-cycle pass-through). Capture inst_rdata into the hold register.
  - stall=0: go to REQ, so the next PC is requested in the following cycle.
  - stall=1: go to HOLD.
- flush and !inst_data_ok: go to DISCARD.
- flush and inst_data_ok: response is dropped (i_data_ok=0), go to REQ.

HOLD:
- i_data_ok=1, instr_=hold register.
- stall=0 or flush: go to REQ.

DISCARD:
- i_data_ok=0.
- inst_data_ok: drop the data, go to REQ.
- A further flush stays in DISCARD.

Other rules:
- i_data_ok=0 in every state/condition not listed above.
- At most one outstanding request. No new request while in WAIT or DISCARD.
- inst_addr is combinational pc. pc is guaranteed stable while stalled except on flush, which masks req that cycle.
- Reset mid-transaction returns to REQ. The bus slave is reset by the same resetn, so no response is expected afterwards.

Test Plan:
- Back-to-back fetch: pc=0xbfc00000, addr_ok same cycle, data_ok next cycle with rdata=0x24080001, stall=0 -> i_data_ok=1 and instr_=0x24080001 in that cycle; inst_req=1 for the next pc one cycle later.
- Hold under stall: data_ok with rdata=0x8c090004 while stall=1 for 3 cycles -> i_data_ok=1, instr_=0x8c090004 all 3 cycles; inst_req=0 until stall falls; then REQ.
- Slow slave: addr_ok delayed 4 cycles -> inst_req stays 1 with inst_addr constant for 5 cycles; exactly one acceptance.
- Flush in WAIT: flush one cycle before data_ok (rdata=0xdeadbeef) -> i_data_ok stays 0, 0xdeadbeef never appears on instr_; new req at redirected pc 0xbfc00380 the cycle after the stale data_ok.
- Misaligned: pc=0xbfc00002 -> inst_req=0, fetch_adel=1, i_data_ok=1, instr_=0 in the same cycle.
- Async reset: assert resetn=0 mid-WAIT without a clock edge -> inst_req and i_data_ok are 0 immediately; after release, REQ at the current pc.
